// File: rtl/serial_hex_pkg.sv
// Shared types and constants for the serial hex display transmitter.
package serial_hex_pkg;

    localparam int FRAME_BITS  = 8;
    localparam int DIV_DEFAULT = 1;

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LATCH} state_t;

endpackage

// File: rtl/serial_hex_tx_if.sv
// Packed pin bundle of the transmitter: io_in carries clock, reset, nibble and strobes.
interface serial_hex_tx_if;

    logic [7:0] io_in;
    logic [7:0] io_out;

    modport master (output io_in, input io_out);
    modport slave  (input io_in, output io_out);

endinterface

// File: rtl/serial_hex_tx_sync_rise.sv
// Two-flop synchronizer plus registered rising-edge detector for an asynchronous strobe.
module sync_rise (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic       s1, s2, s3;
    logic [2:0] vld_pipe;

    // vld_pipe marks when s3 holds a real post-reset sample, so a strobe
    // already high at reset release never looks like a 0->1 transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            vld_pipe <= '0;
            pulse    <= 1'b0;
        end else begin
            s1       <= d;
            s2       <= s1;
            s3       <= s2;
            vld_pipe <= {vld_pipe[1:0], 1'b1};
            pulse    <= vld_pipe[2] & s2 & ~s3;
        end
    end

endmodule

// File: rtl/serial_hex_tx.sv
// Shifts a two-nibble hold register out MSB first on sdata/sclk, then strobes latch.
module serial_hex_tx #(
    parameter int DIV        = serial_hex_pkg::DIV_DEFAULT,
    parameter int FRAME_BITS = serial_hex_pkg::FRAME_BITS
) (
    serial_hex_tx_if.slave bus
);
    import serial_hex_pkg::*;

    localparam logic [2:0] BIT_LAST = 3'(FRAME_BITS - 1);
    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    logic clk, rst;
    assign clk = bus.io_in[0];
    assign rst = bus.io_in[1];

    logic wr_p, st_p;
    sync_rise u_wr (.clk(clk), .rst(rst), .d(bus.io_in[6]), .pulse(wr_p));
    sync_rise u_st (.clk(clk), .rst(rst), .d(bus.io_in[7]), .pulse(st_p));

    state_t                  state, state_n;
    logic [7:0]              div_cnt, div_n;
    logic [2:0]              bit_cnt, bit_n;
    logic [FRAME_BITS-1:0]   sr, sr_n, hold;
    logic [2:0]              wr_cnt;
    logic [3:0]              nib_s1, nib_s2, nib_s3;
    logic                    sdata_q, sclk_q, latch_q, busy_q, done_q, done_n;
    logic                    div_last;

    assign div_last = (div_cnt == DIV_LAST);

    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        sr_n    = sr;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                // A start coinciding with done belongs to the frame just ending.
                if (st_p && !done_q) begin
                    sr_n    = hold;
                    bit_n   = '0;
                    div_n   = '0;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (div_last) begin
                    div_n   = '0;
                    state_n = HIGH;
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end
            HIGH: begin
                if (div_last) begin
                    div_n   = '0;
                    sr_n    = {sr[FRAME_BITS-2:0], 1'b0};
                    bit_n   = bit_cnt + 3'd1;
                    state_n = (bit_cnt == BIT_LAST) ? LATCH : SETUP;
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end
            LATCH: begin
                if (div_last) begin
                    div_n   = '0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nib_s1  <= '0;
            nib_s2  <= '0;
            nib_s3  <= '0;
            hold    <= '0;
            wr_cnt  <= '0;
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            sr      <= '0;
            sdata_q <= 1'b0;
            sclk_q  <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Three stages keep the nibble aligned with the strobe's synchronizer and detector.
            nib_s1 <= bus.io_in[5:2];
            nib_s2 <= nib_s1;
            nib_s3 <= nib_s2;
            if (wr_p) begin
                hold   <= {hold[FRAME_BITS-5:0], nib_s3};
                wr_cnt <= wr_cnt + 3'd1;
            end
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            sr      <= sr_n;
            sdata_q <= ((state_n == SETUP) || (state_n == HIGH)) && sr_n[FRAME_BITS-1];
            sclk_q  <= (state_n == HIGH);
            latch_q <= (state_n == LATCH);
            busy_q  <= (state_n != IDLE);
            done_q  <= done_n;
        end
    end

    assign bus.io_out = {wr_cnt, done_q, busy_q, latch_q, sclk_q, sdata_q};

endmodule
